// File: rtl/varredura_matriz_pkg.sv
// -----------------------------------------------------------------------------
// varredura_matriz_pkg
// Shared definitions for the 5x7 LED matrix column scanner:
//   - state_t      : scan FSM states (IDLE, BLANK, DRIVE)
//   - NUM_COLS     : number of matrix columns (5)
//   - NUM_ROWS     : number of matrix rows (7)
//   - FRAME_W      : width of one packed frame (35)
//   - column_rows(): extracts the row bits of one column from a packed frame
// -----------------------------------------------------------------------------
package varredura_matriz_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    localparam int NUM_COLS = 5;
    localparam int NUM_ROWS = 7;
    localparam int FRAME_W  = NUM_COLS * NUM_ROWS;
    localparam int COL_W    = 3;

    // Column k occupies frame bits [7k+6:7k]; an index outside 0..4 yields 0.
    function automatic logic [NUM_ROWS-1:0] column_rows(
        input logic [FRAME_W-1:0] frame,
        input logic [COL_W-1:0]   idx
    );
        logic [NUM_ROWS-1:0] rows;
        rows = '0;
        for (int k = 0; k < NUM_COLS; k++) begin
            if (idx == COL_W'(k)) begin
                rows = frame[k*NUM_ROWS +: NUM_ROWS];
            end
        end
        return rows;
    endfunction

endpackage

// File: rtl/buffer_quadro.sv
// -----------------------------------------------------------------------------
// buffer_quadro
// Shadow/active frame double buffer with a pending flag.
// A frame offered while no frame is pending is copied into the shadow buffer
// and marked pending. On a swap strobe, a pending shadow frame is copied to
// the active buffer and the pending flag cleared.
// Ports:
//   i_clock        in   clock, rising edge
//   i_reset        in   asynchronous active-high reset (clears both buffers)
//   i_load_valid   in   frame offered on i_load_data
//   i_load_data    in   35-bit frame
//   i_swap         in   frame-boundary strobe from the scanner
//   o_load_ready   out  shadow buffer free (not pending)
//   o_active       out  frame currently displayed
// -----------------------------------------------------------------------------
module buffer_quadro
    import varredura_matriz_pkg::*;
(
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_load_valid,
    input  logic [FRAME_W-1:0] i_load_data,
    input  logic               i_swap,
    output logic               o_load_ready,
    output logic [FRAME_W-1:0] o_active
);

    logic [FRAME_W-1:0] r_shadow;
    logic [FRAME_W-1:0] r_active;
    logic               r_pending;
    logic               w_accept;

    assign w_accept     = i_load_valid & ~r_pending;
    assign o_load_ready = ~r_pending;
    assign o_active     = r_active;

    // Swap and accept both look at the pending flag before the edge, so a
    // frame accepted on a boundary edge waits for the following boundary.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (i_swap && r_pending) begin
                r_active <= r_shadow;
            end
            if (w_accept) begin
                r_shadow <= i_load_data;
            end
            r_pending <= w_accept | (r_pending & ~i_swap);
        end
    end

endmodule

// File: rtl/varredura_matriz.sv
// -----------------------------------------------------------------------------
// varredura_matriz
// Column scanner for a 5x7 LED matrix. Each column is preceded by an all-off
// blanking interval and then driven for a fixed dwell time. New frames are
// double-buffered and swapped in only at frame boundaries.
// Optional feature macro: VARREDURA_BRIGHTNESS_EN -- when defined, the row
// data is cut off part-way through the dwell according to i_brightness.
// Parameters:
//   DWELL_CYCLES   cycles each column is driven (multiple of 8, >= 8)
//   BLANK_CYCLES   all-off cycles before each column (>= 1)
// Ports:
//   i_clock        in   sole clock, rising edge
//   i_reset        in   asynchronous active-high reset
//   i_enable       in   scan runs while 1, forced idle while 0
//   i_load_valid   in   frame offered on i_load_data
//   i_load_data    in   frame; bits [7k+6:7k] are rows 6..0 of column k
//   o_load_ready   out  shadow buffer free
//   i_brightness   in   dimming level (only with VARREDURA_BRIGHTNESS_EN)
//   o_counter      out  column index 0..4
//   o_col          out  one-hot column enable
//   o_row          out  row data for the driven column
//   o_frame_done   out  pulse on the last drive cycle of column 4
// -----------------------------------------------------------------------------
module varredura_matriz
    import varredura_matriz_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_load_valid,
    input  logic [FRAME_W-1:0]  i_load_data,
    output logic                o_load_ready,
    input  logic [2:0]          i_brightness,
    output logic [2:0]          o_counter,
    output logic [NUM_COLS-1:0] o_col,
    output logic [NUM_ROWS-1:0] o_row,
    output logic                o_frame_done
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [2:0]       LAST_COL   = 3'(NUM_COLS - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [2:0]         r_counter;
    logic [2:0]         w_counter_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_swap;
    logic               w_drive;
    logic               w_row_on;
    logic [FRAME_W-1:0] w_active;

    buffer_quadro u_buffer (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_load_valid (i_load_valid),
        .i_load_data  (i_load_data),
        .i_swap       (w_swap),
        .o_load_ready (o_load_ready),
        .o_active     (w_active)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_counter <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_counter <= w_counter_next;
            r_cnt     <= w_cnt_next;
        end
    end

    // r_cnt is shared between the blank and dwell intervals; it restarts at 0
    // on every state change. w_swap marks the edges where a pending frame may
    // be promoted: leaving IDLE and wrapping from column 4 back to column 0.
    always_comb begin
        w_state_next   = r_state;
        w_counter_next = r_counter;
        w_cnt_next     = r_cnt;
        w_swap         = 1'b0;
        if (!i_enable) begin
            w_state_next   = ST_IDLE;
            w_counter_next = '0;
            w_cnt_next     = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next   = ST_BLANK;
                    w_counter_next = '0;
                    w_cnt_next     = '0;
                    w_swap         = 1'b1;
                end
                ST_BLANK: begin
                    if (r_cnt == BLANK_LAST) begin
                        w_state_next = ST_DRIVE;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                ST_DRIVE: begin
                    if (r_cnt == DWELL_LAST) begin
                        w_state_next = ST_BLANK;
                        w_cnt_next   = '0;
                        if (r_counter == LAST_COL) begin
                            w_counter_next = '0;
                            w_swap         = 1'b1;
                        end else begin
                            w_counter_next = r_counter + 3'd1;
                        end
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_next   = ST_IDLE;
                    w_counter_next = '0;
                    w_cnt_next     = '0;
                end
            endcase
        end
    end

`ifdef VARREDURA_BRIGHTNESS_EN
    // Brightness is captured in a register so that the row outputs depend
    // on registered state only; a level change takes effect one cycle later.
    localparam int STEP = DWELL_CYCLES / 8;

    logic [2:0]  r_brightness;
    logic [31:0] w_limit;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_brightness <= '0;
        end else begin
            r_brightness <= i_brightness;
        end
    end

    assign w_limit  = (32'(r_brightness) + 32'd1) * 32'(STEP);
    assign w_row_on = (32'(r_cnt) < w_limit);
`else
    logic w_unused_brightness;
    assign w_unused_brightness = ^i_brightness;
    assign w_row_on            = 1'b1;
`endif

    assign w_drive      = (r_state == ST_DRIVE);
    assign o_counter    = r_counter;
    assign o_col        = w_drive ? (NUM_COLS'(1) << r_counter) : '0;
    assign o_row        = (w_drive && w_row_on) ? column_rows(w_active, r_counter) : '0;
    assign o_frame_done = w_drive && (r_counter == LAST_COL) && (r_cnt == DWELL_LAST);

endmodule

// File: tb/tb_varredura_matriz.sv
// -----------------------------------------------------------------------------
// tb_varredura_matriz
// Scoreboard bench for varredura_matriz (DWELL_CYCLES=8, BLANK_CYCLES=2).
// The reference model tracks the number of cycles since the scan started and
// derives column, blanking and frame boundaries arithmetically from it.
// -----------------------------------------------------------------------------
module tb_varredura_matriz;

    localparam int DW = 8;
    localparam int BL = 2;
    localparam int P  = DW + BL;
    localparam int FR = 5 * P;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        lv;
    logic [34:0] ld;
    logic        lr;
    logic [2:0]  br;
    logic [2:0]  cnt;
    logic [4:0]  col;
    logic [6:0]  row;
    logic        fd;

    always #5 clk = ~clk;

    varredura_matriz #(
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (BL)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_enable     (en),
        .i_load_valid (lv),
        .i_load_data  (ld),
        .o_load_ready (lr),
        .i_brightness (br),
        .o_counter    (cnt),
        .o_col        (col),
        .o_row        (row),
        .o_frame_done (fd)
    );

    int total = 0;
    int bad   = 0;

    // Expected outputs packed as {load_ready, frame_done, counter, col, row}.
    logic [16:0] sb[$];

    // Model state: m_t = cycles since scan start (-1 when idle).
    int          m_t;
    logic [34:0] m_act;
    logic [34:0] m_sh;
    logic        m_pend;
    logic [2:0]  m_br;

    function automatic logic [16:0] expect_out();
        int pos, k, w;
        logic [6:0] r;
        logic [4:0] c;
        logic       f;
        if (m_t < 0) return {~m_pend, 1'b0, 3'd0, 5'd0, 7'd0};
        pos = m_t % FR;
        k   = pos / P;
        w   = pos % P;
        c   = '0;
        r   = '0;
        f   = 1'b0;
        if (w >= BL) begin
            c = 5'd1 << k;
            r = m_act[k*7 +: 7];
`ifdef VARREDURA_BRIGHTNESS_EN
            if ((w - BL) >= (int'(m_br) + 1) * (DW / 8)) r = '0;
`endif
            f = (k == 4) && (w == P - 1);
        end
        return {~m_pend, f, 3'(k), c, r};
    endfunction

    always @(posedge clk) begin : model_p
        int nt;
        bit acc;
        bit bnd;
        if (rst) begin
            m_t    = -1;
            m_act  = '0;
            m_sh   = '0;
            m_pend = 1'b0;
            m_br   = '0;
        end else begin
            bnd = 1'b0;
            if (!en) begin
                nt = -1;
            end else if (m_t < 0) begin
                nt  = 0;
                bnd = 1'b1;
            end else begin
                nt  = m_t + 1;
                bnd = ((nt % FR) == 0);
            end
            acc = lv && !m_pend;
            if (bnd && m_pend) begin
                m_act  = m_sh;
                m_pend = 1'b0;
            end
            if (acc) begin
                m_sh   = ld;
                m_pend = 1'b1;
            end
            m_t  = nt;
            m_br = br;
        end
        sb.push_back(expect_out());
    end

    always @(posedge clk) begin : mon_p
        logic [16:0] e;
        #2;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty t=%0t", $time);
        end else begin
            e = sb.pop_front();
            if ({lr, fd, cnt, col, row} !== e) begin
                bad++;
                $display("FAIL outputs t=%0t got lr=%b fd=%b cnt=%0d col=%b row=%h need lr=%b fd=%b cnt=%0d col=%b row=%h",
                         $time, lr, fd, cnt, col, row, e[16], e[15], e[14:12], e[11:7], e[6:0]);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string nm, input int got, input int need);
        total++;
        if (got != need) begin
            bad++;
            $display("FAIL %s got=%0h need=%0h", nm, got, need);
        end
    endtask

    // mode 0: next edge is a frame boundary; 1: driving column k; 2: mid-frame
    function automatic bit cond_met(input int mode, input int k);
        if (m_t < 0) return 1'b0;
        case (mode)
            0:       return (m_t % FR) == FR - 1;
            1:       return ((m_t % FR) / P == k) && ((m_t % P) >= BL);
            default: return (m_t % FR) == FR / 2;
        endcase
    endfunction

    task automatic wait_until(input int mode, input int k);
        for (int i = 0; i < 300; i++) begin
            if (cond_met(mode, k)) return;
            @(negedge clk);
        end
        total++;
        bad++;
        $display("FAIL wait_timeout mode=%0d col=%0d", mode, k);
    endtask

    initial begin
        logic [63:0] rnd;
        rst = 1'b1;
        en  = 1'b1;
        lv  = 1'b0;
        ld  = '0;
        br  = 3'd7;
        cyc(3);
        rst = 1'b0;
        cyc(60);

        // Frame loaded while idle is shown as soon as the scan starts.
        en = 1'b0;
        cyc(2);
        ld = 35'h1_2345_6789;
        lv = 1'b1;
        cyc(1);
        lv = 1'b0;
        cyc(2);
        en = 1'b1;
        wait_until(1, 0);
        check("col0_row", int'(row), 'h09);
        wait_until(1, 1);
        check("col1_row", int'(row), 'h4F);
        cyc(20);

        // Mid-frame accept, then a second offer that must stall.
        wait_until(2, 0);
        ld = 35'h2_AAAA_5555;
        lv = 1'b1;
        cyc(1);
        check("ready_after_accept", int'(lr), 0);
        ld = 35'h5_0F0F_F0F0;
        cyc(60);
        lv = 1'b0;
        cyc(60);

        // Accept exactly on the boundary edge.
        wait_until(0, 0);
        ld = 35'h3_1234_ABCD;
        lv = 1'b1;
        cyc(1);
        lv = 1'b0;
        cyc(2 * FR + 10);

        // Drop enable while driving column 2.
        wait_until(1, 2);
        en = 1'b0;
        cyc(1);
        check("idle_col", int'(col), 0);
        check("idle_counter", int'(cnt), 0);
        cyc(2);
        en = 1'b1;
        cyc(30);

        // Reset mid-frame with a frame pending.
        wait_until(2, 0);
        ld = 35'h7_FFFF_FFFF;
        lv = 1'b1;
        cyc(1);
        lv = 1'b0;
        cyc(3);
        rst = 1'b1;
        cyc(2);
        check("reset_ready", int'(lr), 1);
        rst = 1'b0;
        cyc(2);
        ld = 35'h6_DEAD_BEEF;
        lv = 1'b1;
        cyc(1);
        lv = 1'b0;
        cyc(FR + 5);

        // Brightness sweep.
        for (int b = 0; b < 8; b++) begin
            br = 3'(b);
            cyc(FR);
        end

        // Randomized traffic.
        repeat (1500) begin
            rnd = {$urandom(), $urandom()};
            en  = ($urandom_range(0, 99) != 0);
            lv  = ($urandom_range(0, 9) == 0);
            ld  = rnd[34:0];
            br  = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 499) == 0);
            cyc(1);
        end
        rst = 1'b0;
        en  = 1'b0;
        lv  = 1'b0;
        cyc(3);

        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
